// File: rtl/mips_wb_pkg.sv
// Shared types for the MIPS writeback stage: load-type codes, FSM states,
// and the bundled GRF write record.
package mips_wb_pkg;

  typedef enum logic [2:0] {
    LT_LB  = 3'd0,
    LT_LBU = 3'd1,
    LT_LH  = 3'd2,
    LT_LHU = 3'd3,
    LT_LW  = 3'd4,
    LT_LWL = 3'd5,
    LT_LWR = 3'd6
  } load_type_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_e;

  // One GRF write; all-zero means "no write".
  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
    logic [31:0] pc;
  } wb_wr_t;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM->WB handshake, memory return, GRF write port and forwarding status.
// master = MEM side / memory, slave = writeback stage.
interface writeback_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_dest;
  logic [31:0] in_result;
  logic        in_is_load;
  logic [2:0]  in_load_type;
  logic [31:0] in_rt_old;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        in_flush;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        fwd_busy;
  logic [4:0]  fwd_dest;

  modport master (
    output in_valid, in_pc, in_dest, in_result, in_is_load, in_load_type,
           in_rt_old, mem_rvalid, mem_rdata, in_flush,
    input  in_ready, wb_addr, wb_data, wb_pc, fwd_busy, fwd_dest
  );

  modport slave (
    input  in_valid, in_pc, in_dest, in_result, in_is_load, in_load_type,
           in_rt_old, mem_rvalid, mem_rdata, in_flush,
    output in_ready, wb_addr, wb_data, wb_pc, fwd_busy, fwd_dest
  );
endinterface

// File: rtl/writeback_stage_load_align.sv
// load_align: byte/halfword extraction with sign/zero extension, LW pass-through.
// With WB_UNALIGNED_LOAD_EN defined, LWL/LWR merge the loaded word into rt_old
// (little-endian); otherwise LWL/LWR behave as LW.
module load_align
  import mips_wb_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_old,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[{offset, 3'b000} +: 8];
  assign half_v = offset[1] ? rdata[31:16] : rdata[15:0];

`ifdef WB_UNALIGNED_LOAD_EN
  // LWL keeps the low (3-offset) bytes of rt; LWR keeps the high offset bytes.
  logic [4:0] sh_l, sh_r;
  assign sh_l = {~offset, 3'b000};
  assign sh_r = {offset, 3'b000};
`else
  logic unused_rt;
  assign unused_rt = ^rt_old;
`endif

  // Select the extension/merge for the load kind.
  always_comb begin
    data = rdata;
    case (load_type)
      LT_LB:  data = {{24{byte_v[7]}}, byte_v};
      LT_LBU: data = {24'd0, byte_v};
      LT_LH:  data = {{16{half_v[15]}}, half_v};
      LT_LHU: data = {16'd0, half_v};
`ifdef WB_UNALIGNED_LOAD_EN
      LT_LWL: data = (rdata << sh_l) | (rt_old & ~(32'hFFFF_FFFF << sh_l));
      LT_LWR: data = (rdata >> sh_r) | (rt_old & ~(32'hFFFF_FFFF >> sh_r));
`endif
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: retires MEM-stage instructions into the GRF write port.
// Loads without data in the accept cycle park in WAIT until mem_rvalid.
// Optional feature macro: WB_UNALIGNED_LOAD_EN (LWL/LWR merge in load_align).
module writeback_stage
  import mips_wb_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  writeback_stage_if.slave bus
);

  wb_state_e   state_q, state_d;

  // Pending-load context latched on entry to WAIT.
  logic [4:0]  p_dest;
  logic [31:0] p_pc, p_rt;
  logic [2:0]  p_type;
  logic [1:0]  p_off;

  // Output register and a one-entry hold. The hold only fills when a load
  // finishing from WAIT and a newly accepted instruction complete in the same
  // cycle; the younger one is then written one cycle later.
  wb_wr_t      out_q, hold_q;
  logic        hold_v;

  logic        accept, wait_done, new_done, new_wait, in_wait;
  logic [31:0] load_data;
  wb_wr_t      new_wr, wait_wr, first_wr;
  logic        first_v, second_v;

  assign in_wait      = (state_q == WAIT);
  assign bus.in_ready = !in_wait || bus.mem_rvalid;
  assign accept       = bus.in_valid && bus.in_ready;
  assign wait_done    = in_wait && bus.mem_rvalid && !bus.in_flush;
  // In WAIT, this cycle's mem_rvalid belongs to the parked load, so a newly
  // accepted load can only complete immediately from IDLE.
  assign new_done     = accept && (!bus.in_is_load || (!in_wait && bus.mem_rvalid));
  assign new_wait     = accept && bus.in_is_load && !new_done;

  // At most one load needs alignment per cycle: the parked one in WAIT, or
  // a same-cycle load from IDLE.
  load_align u_align (
    .load_type (in_wait ? p_type : bus.in_load_type),
    .offset    (in_wait ? p_off  : bus.in_result[1:0]),
    .rdata     (bus.mem_rdata),
    .rt_old    (in_wait ? p_rt   : bus.in_rt_old),
    .data      (load_data)
  );

  // Assemble candidate writes, oldest first.
  always_comb begin
    new_wr   = '{dest: bus.in_dest,
                 data: bus.in_is_load ? load_data : bus.in_result,
                 pc:   bus.in_pc};
    wait_wr  = '{dest: p_dest, data: load_data, pc: p_pc};
    first_wr = '0;
    first_v  = 1'b0;
    if (hold_v) begin
      first_wr = hold_q;
      first_v  = 1'b1;
    end else if (wait_done) begin
      first_wr = wait_wr;
      first_v  = 1'b1;
    end else if (new_done) begin
      first_wr = new_wr;
      first_v  = 1'b1;
    end
    second_v = (hold_v || wait_done) && new_done;
  end

  // Next-state: leave WAIT on data or flush; enter WAIT on a parked load.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (new_wait) state_d = WAIT;
      WAIT:    if (bus.mem_rvalid || bus.in_flush) state_d = new_wait ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Latch pending-load context.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_dest <= '0;
      p_pc   <= '0;
      p_rt   <= '0;
      p_type <= '0;
      p_off  <= '0;
    end else if (new_wait) begin
      p_dest <= bus.in_dest;
      p_pc   <= bus.in_pc;
      p_rt   <= bus.in_rt_old;
      p_type <= bus.in_load_type;
      p_off  <= bus.in_result[1:0];
    end
  end

  // GRF write register and overflow hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      hold_q <= '0;
      hold_v <= 1'b0;
    end else begin
      out_q  <= first_v ? first_wr : '0;
      hold_v <= second_v;
      hold_q <= second_v ? new_wr : '0;
    end
  end

  assign bus.wb_addr  = out_q.dest;
  assign bus.wb_data  = out_q.data;
  assign bus.wb_pc    = out_q.pc;
  assign bus.fwd_busy = in_wait;
  assign bus.fwd_dest = in_wait ? p_dest : 5'd0;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  writeback_stage_if bus ();

  writeback_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] dest, input logic [31:0] res,
                       input logic [31:0] pc, input logic ld, input logic [2:0] lt,
                       input logic [31:0] rt, input logic rv, input logic [31:0] rd,
                       input logic fl);
    bus.in_valid     = v;
    bus.in_dest      = dest;
    bus.in_result    = res;
    bus.in_pc        = pc;
    bus.in_is_load   = ld;
    bus.in_load_type = lt;
    bus.in_rt_old    = rt;
    bus.mem_rvalid   = rv;
    bus.mem_rdata    = rd;
    bus.in_flush     = fl;
  endtask

  task automatic idle_in();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, {27'd0, bus.wb_addr}, 32'd0);
    chk({tag, "_data"}, bus.wb_data, 32'd0);
    chk({tag, "_pc"},   bus.wb_pc,   32'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    cycle();
    cycle();
    chk_zero("reset");
    chk("reset_busy",  {31'd0, bus.fwd_busy}, 32'd0);
    chk("reset_fdest", {27'd0, bus.fwd_dest}, 32'd0);
    chk("reset_ready", {31'd0, bus.in_ready}, 32'd1);
    reset = 1'b0;
    cycle();

    // Non-load: one-cycle write then idle.
    drive(1'b1, 5'd5, 32'h1234_5678, 32'hBFC0_0010, 1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    cycle();
    idle_in();
    chk("alu_addr", {27'd0, bus.wb_addr}, 32'd5);
    chk("alu_data", bus.wb_data, 32'h1234_5678);
    chk("alu_pc",   bus.wb_pc,   32'hBFC0_0010);
    cycle();
    chk_zero("alu_after");

    // Same-cycle loads.
    drive(1'b1, 5'd7, 32'h0000_0103, 32'h100, 1'b1, 3'd0, 32'd0, 1'b1, 32'h80FF_FFFF, 1'b0);
    cycle();
    chk("lb_data", bus.wb_data, 32'hFFFF_FF80);
    chk("lb_addr", {27'd0, bus.wb_addr}, 32'd7);
    chk("lb_busy", {31'd0, bus.fwd_busy}, 32'd0);
    drive(1'b1, 5'd7, 32'h0000_0103, 32'h104, 1'b1, 3'd1, 32'd0, 1'b1, 32'h80FF_FFFF, 1'b0);
    cycle();
    chk("lbu_data", bus.wb_data, 32'h0000_0080);
    drive(1'b1, 5'd8, 32'h0000_0101, 32'h108, 1'b1, 3'd0, 32'd0, 1'b1, 32'h0000_7F00, 1'b0);
    cycle();
    chk("lb_pos_data", bus.wb_data, 32'h0000_007F);
    drive(1'b1, 5'd8, 32'h0000_0203, 32'h10C, 1'b1, 3'd3, 32'd0, 1'b1, 32'h8001_1234, 1'b0);
    cycle();
    chk("lhu_data", bus.wb_data, 32'h0000_8001);
    drive(1'b1, 5'd8, 32'h0000_0202, 32'h110, 1'b1, 3'd4, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    cycle();
    chk("lw_data", bus.wb_data, 32'hDEAD_BEEF);
    chk("lw_pc",   bus.wb_pc,   32'h0000_0110);

    // LH with data 3 cycles late.
    drive(1'b1, 5'd9, 32'h0000_0302, 32'h200, 1'b1, 3'd2, 32'd0, 1'b0, 32'd0, 1'b0);
    cycle();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lh_wait_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("lh_wait_busy",  {31'd0, bus.fwd_busy}, 32'd1);
      chk("lh_wait_fdest", {27'd0, bus.fwd_dest}, 32'd9);
      chk("lh_wait_addr",  {27'd0, bus.wb_addr},  32'd0);
      cycle();
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h8001_0000;
    #1;
    chk("lh_rv_ready", {31'd0, bus.in_ready}, 32'd1);
    cycle();
    idle_in();
    chk("lh_data", bus.wb_data, 32'hFFFF_8001);
    chk("lh_addr", {27'd0, bus.wb_addr}, 32'd9);
    chk("lh_pc",   bus.wb_pc,   32'h0000_0200);
    chk("lh_busy", {31'd0, bus.fwd_busy}, 32'd0);

    // Flush beats simultaneous mem_rvalid.
    drive(1'b1, 5'd10, 32'h0, 32'h300, 1'b1, 3'd4, 32'd0, 1'b0, 32'd0, 1'b0);
    cycle();
    idle_in();
    bus.in_flush   = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    cycle();
    idle_in();
    chk_zero("flush");
    chk("flush_busy",  {31'd0, bus.fwd_busy}, 32'd0);
    chk("flush_ready", {31'd0, bus.in_ready}, 32'd1);

    // LWL / LWR.
    drive(1'b1, 5'd11, 32'h0000_0401, 32'h400, 1'b1, 3'd5, 32'h1122_3344, 1'b1, 32'hAABB_CCDD, 1'b0);
    cycle();
`ifdef WB_UNALIGNED_LOAD_EN
    chk("lwl_data", bus.wb_data, 32'hCCDD_3344);
`else
    chk("lwl_data", bus.wb_data, 32'hAABB_CCDD);
`endif
    drive(1'b1, 5'd11, 32'h0000_0402, 32'h404, 1'b1, 3'd6, 32'h1122_3344, 1'b1, 32'hAABB_CCDD, 1'b0);
    cycle();
    idle_in();
`ifdef WB_UNALIGNED_LOAD_EN
    chk("lwr_data", bus.wb_data, 32'h1122_AABB);
`else
    chk("lwr_data", bus.wb_data, 32'hAABB_CCDD);
`endif
    cycle();

    // Reset while in WAIT discards the load.
    drive(1'b1, 5'd12, 32'h0, 32'h500, 1'b1, 3'd4, 32'd0, 1'b0, 32'd0, 1'b0);
    cycle();
    idle_in();
    chk("rstw_busy_pre", {31'd0, bus.fwd_busy}, 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk_zero("rstw");
    chk("rstw_busy",  {31'd0, bus.fwd_busy}, 32'd0);
    chk("rstw_fdest", {27'd0, bus.fwd_dest}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_2222;
    cycle();
    idle_in();
    chk_zero("rstw_late");

    // Flush in IDLE does not block an accept.
    drive(1'b1, 5'd3, 32'h0000_0055, 32'h600, 1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    cycle();
    idle_in();
    chk("idleflush_addr", {27'd0, bus.wb_addr}, 32'd3);
    chk("idleflush_data", bus.wb_data, 32'h0000_0055);

    // Stray mem_rvalid in IDLE is ignored.
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h7777_7777;
    cycle();
    idle_in();
    chk_zero("stray_rv");

    // Back-to-back: new load accepted in the completion cycle of a parked one.
    drive(1'b1, 5'd13, 32'h0000_0700, 32'h700, 1'b1, 3'd4, 32'd0, 1'b0, 32'd0, 1'b0);
    cycle();
    drive(1'b1, 5'd14, 32'h0000_0701, 32'h704, 1'b1, 3'd1, 32'd0, 1'b1, 32'h0000_00AB, 1'b0);
    cycle();
    idle_in();
    chk("b2b_first_addr", {27'd0, bus.wb_addr}, 32'd13);
    chk("b2b_first_data", bus.wb_data, 32'h0000_00AB);
    chk("b2b_busy",       {31'd0, bus.fwd_busy}, 32'd1);
    chk("b2b_fdest",      {27'd0, bus.fwd_dest}, 32'd14);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000_9900;
    cycle();
    idle_in();
    chk("b2b_second_addr", {27'd0, bus.wb_addr}, 32'd14);
    chk("b2b_second_data", bus.wb_data, 32'h0000_0099);
    chk("b2b_second_pc",   bus.wb_pc,   32'h0000_0704);

    // Load to r0 still waits.
    drive(1'b1, 5'd0, 32'h0, 32'h800, 1'b1, 3'd4, 32'd0, 1'b0, 32'd0, 1'b0);
    cycle();
    idle_in();
    chk("r0_busy", {31'd0, bus.fwd_busy}, 32'd1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_0000;
    cycle();
    idle_in();
    chk("r0_addr",      {27'd0, bus.wb_addr},  32'd0);
    chk("r0_busy_done", {31'd0, bus.fwd_busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 in_valid  input  1  MEM-stage instruction valid.
REQ-004 in_ready  output  1  stage can accept; comb: (state!=WAIT) || mem_rvalid.
REQ-005 in_pc  input  32  instruction PC.
REQ-006 in_dest  input  5  destination GPR; 0 = no write.
REQ-007 in_result  input  32  ALU result; load byte address for loads.
REQ-008 in_is_load  input  1  instruction is a load.
REQ-009 in_load_type  input  3  load kind, encoding per package.
REQ-010 in_rt_old  input  32  current rt value, for LWL/LWR merge.
REQ-011 mem_rvalid  input  1  load data valid this cycle.
REQ-012 mem_rdata  input  32  aligned load word, little-endian.
REQ-013 in_flush  input  1  discard held load (exception/ERET).
REQ-014 wb_addr  output  5  GRF write address; 0 when idle.
REQ-015 wb_data  output  32  GRF write data.
REQ-016 wb_pc  output  32  PC of written instruction, to GRF debug PC.
REQ-017 fwd_busy  output  1  load pending in WAIT; fwd_dest valid.
REQ-018 fwd_dest  output  5  dest of pending load, for hazard stall.

Function
REQ-019 States SHALL be IDLE and WAIT; accept = in_valid && in_ready.
REQ-020 Non-load accept in cycle N SHALL drive wb_addr=in_dest, wb_data=in_result, wb_pc=in_pc in cycle N+1 only.
REQ-021 Load accept in N with mem_rvalid in N SHALL write aligned data in N+1; state stays IDLE.
REQ-022 Load accept without mem_rvalid SHALL latch dest, pc, type, offset in_result[1:0], rt_old and go to WAIT.
REQ-023 In WAIT, mem_rvalid in cycle M SHALL write in M+1, return to IDLE; a new accept in M is legal.
REQ-024 Any cycle without a completing instruction SHALL drive wb_addr=0, wb_data=0, wb_pc=0 (GRF ignores address 0).
REQ-025 Loads with dest 0 SHALL still wait for mem_rvalid; the resulting write goes to address 0 (dropped).
REQ-026 LB/LH SHALL sign-extend, LBU/LHU zero-extend the byte/halfword at the latched offset; LH/LHU use offset[1] only.
REQ-027 LW SHALL ignore the offset and pass mem_rdata.
REQ-028 in_flush in WAIT SHALL return to IDLE with no write; flush wins over simultaneous mem_rvalid.
REQ-029 in_flush in IDLE SHALL be ignored; in_flush does not block a same-cycle accept.
REQ-030 mem_rvalid in IDLE with no load accepted SHALL be ignored.

Reset
REQ-031 reset SHALL force IDLE, wb_addr=0, wb_data=0, wb_pc=0, fwd_busy=0, fwd_dest=0 next cycle.
REQ-032 reset during WAIT SHALL discard the pending load; no write follows.

Configuration
REQ-033 Macro WB_UNALIGNED_LOAD_EN defined: LWL/LWR merge mem_rdata into rt_old per MIPS32 little-endian rules using the latched offset.
REQ-034 Macro undefined: LWL/LWR codes SHALL behave exactly as LW.

Structure
REQ-035 Package mips_wb_pkg SHALL hold load-type codes (LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6) and the state enum.
REQ-036 Combinational sub-module load_align SHALL perform extraction, extension and LWL/LWR merge.

Verification
REQ-037 Non-load dest 5, result 0x1234_5678, pc 0xBFC0_0010 at cycle N -> wb_addr=5, wb_data=0x1234_5678, wb_pc=0xBFC0_0010 at N+1, then wb_addr=0.
REQ-038 LB addr offset 3, rdata 0x80FF_FFFF same cycle -> wb_data=0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-039 LH offset 2, rdata arriving 3 cycles late 0x8001_0000 -> in_ready=0 and fwd_busy=1 for 3 cycles, then wb_data=0xFFFF_8001.
REQ-040 Load in WAIT, in_flush and mem_rvalid same cycle -> no write, IDLE, in_ready=1 next cycle.
REQ-041 With macro, LWL offset 1, rdata 0xAABB_CCDD, rt_old 0x1122_3344 -> wb_data=0xCCDD_3344; without macro -> 0xAABB_CCDD.
REQ-042 reset asserted while in WAIT -> all outputs 0 next cycle; later mem_rvalid produces no write.
